regfile_wb_ctrl: RTL

//  Writeback stage directly upstream of the register file: sole driver of its RegWrite/Rd/Write_data.

---
 rtl/rv32_wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_wb_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv32_wb_pkg.sv
// rtl/rv32_wb_pkg.sv - shared types and constants for the writeback stage
package rv32_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  // One pending register-file write: destination and value
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Which path produced the write currently held in the output register
  typedef enum logic {
    WB_SRC_ALU,
    WB_SRC_FIFO
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result buffer holding wb_req_t entries
module wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wb_req_t       i_push_data,
  input  logic          i_pop,
  output wb_req_t       o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow so callers can't corrupt the pointers
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count disambiguates full/empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - writeback arbiter, output register and load scoreboard
module regfile_wb_ctrl
  import rv32_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [REG_AW-1:0]           alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [REG_AW-1:0]           mem_rd,
  input  logic [XLEN-1:0]             mem_data,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_rd,
  output logic                        RegWrite,
  output logic [REG_AW-1:0]           Rd,
  output logic [XLEN-1:0]             Write_data,
  output logic [NREG-1:0]             pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              r_regwrite;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_wdata;
  wb_src_e           r_src;
  logic [NREG-1:0]   r_pending;

  logic              w_alu_win;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  wb_req_t           w_push_req;
  wb_req_t           w_head;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_pending_nxt;

  // A write to x0 from the ALU is a no-op and must not steal the slot from the FIFO
  assign w_alu_win = alu_valid && (alu_rd != '0);

  // Ready only looks at current occupancy: a same-cycle pop does not free a slot early
  assign mem_ready  = !reset && !w_full;
  assign w_push     = mem_valid && mem_ready && (mem_rd != '0);
  assign w_pop      = !w_alu_win && !w_empty;
  assign w_push_req = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Output register: ALU first, then FIFO head; Rd/data hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_src      <= WB_SRC_ALU;
    end else if (w_alu_win) begin
      r_regwrite <= 1'b1;
      r_rd       <= alu_rd;
      r_wdata    <= alu_data;
      r_src      <= WB_SRC_ALU;
    end else if (w_pop) begin
      r_regwrite <= 1'b1;
      r_rd       <= w_head.rd;
      r_wdata    <= w_head.data;
      r_src      <= WB_SRC_FIFO;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  // Scoreboard update: a load clears its bit as the reg file captures it; a new issue wins
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid && (issue_rd != '0)) begin
      w_set_mask[issue_rd] = 1'b1;
    end
    if (r_regwrite && (r_src == WB_SRC_FIFO)) begin
      w_clr_mask[r_rd] = 1'b1;
    end
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // An ALU result targeting a register still awaiting a load means decode failed to stall
  a_no_alu_to_pending : assert property (
    @(posedge clk) disable iff (reset)
      w_alu_win |-> !r_pending[alu_rd]
  );

  assign RegWrite   = r_regwrite;
  assign Rd         = r_rd;
  assign Write_data = r_wdata;
  assign pending    = r_pending;
  assign fifo_count = w_count;

endmodule
